// File: rtl/qa1_button_counter.sv
// qa1 quiz board input front end: button sync/debounce, press strobes,
// and a modulo up/down/load/clear counter driving the LED banks.
module qa1_button_counter #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_MAX         = 7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] push_button,
  input  logic [7:0] toggle_switch,
  output logic [3:0] press_pulse,
  output logic       press_valid,
  output logic [1:0] press_index,
  output logic [3:0] count,
  output logic [3:0] green_led,
  output logic [6:0] red_led
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    MAXV    = 4'(CNT_MAX);

  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    stable;
  logic [3:0]    stable_q;
  logic [CW-1:0] db_cnt [4];
  logic [3:0]    rise;
  logic [1:0]    rise_idx;
  logic [3:0]    load_val;
  logic [3:0]    count_nxt;
  logic [6:0]    red_nxt;
  logic          unused_sw;

  assign unused_sw = ^toggle_switch[7:4];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= '0;
      s2       <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      s1       <= push_button;
      s2       <= s1;
      stable_q <= stable;
      // any return to the accepted level restarts the window
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    rise     = stable & ~stable_q;
    rise_idx = 2'd0;
    priority case (1'b1)
      rise[0]: rise_idx = 2'd0;
      rise[1]: rise_idx = 2'd1;
      rise[2]: rise_idx = 2'd2;
      rise[3]: rise_idx = 2'd3;
      default: rise_idx = 2'd0;
    endcase
  end

  always_comb begin
    load_val  = (toggle_switch[3:0] > MAXV) ? MAXV : toggle_switch[3:0];
    count_nxt = count;
    // clear beats load beats down beats up
    priority case (1'b1)
      press_pulse[3]: count_nxt = '0;
      press_pulse[2]: count_nxt = load_val;
      press_pulse[1]: count_nxt = (count == 4'd0) ? MAXV : count - 4'd1;
      press_pulse[0]: count_nxt = (count == MAXV) ? 4'd0 : count + 4'd1;
      default:        count_nxt = count;
    endcase
    red_nxt = '0;
    for (int i = 0; i < 7; i++) begin
      red_nxt[i] = (count_nxt > 4'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      press_pulse <= '0;
      press_valid <= 1'b0;
      press_index <= '0;
      count       <= '0;
      green_led   <= MAXV;
      red_led     <= '0;
    end else begin
      press_pulse <= rise;
      press_valid <= |rise;
      press_index <= rise_idx;
      count       <= count_nxt;
      green_led   <= MAXV - count_nxt;
      red_led     <= red_nxt;
    end
  end

endmodule

// File: tb/tb_qa1_button_counter.sv
// Bench for qa1_button_counter: windowed debounce reference model feeding
// a pulse/count scoreboard, plus directed and random button traffic.
module tb_qa1_button_counter;

  localparam int D  = 4;
  localparam int CM = 7;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] push_button = '0;
  logic [7:0] toggle_switch = '0;
  logic [3:0] press_pulse;
  logic       press_valid;
  logic [1:0] press_index;
  logic [3:0] count;
  logic [3:0] green_led;
  logic [6:0] red_led;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] pulse;
    logic [1:0] idx;
    int         cnt;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] hist[$];
  logic [3:0] m_stable;
  int         m_count;

  always #5 clock = ~clock;

  qa1_button_counter #(
    .DEBOUNCE_CYCLES(D),
    .CNT_MAX(CM)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .push_button(push_button),
    .toggle_switch(toggle_switch),
    .press_pulse(press_pulse),
    .press_valid(press_valid),
    .press_index(press_index),
    .count(count),
    .green_led(green_led),
    .red_led(red_led)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(4'h0);
    m_stable = '0;
    m_count  = 0;
    sb.delete();
  endtask

  // Reference: a level is accepted once the synchronized button has shown
  // the opposite level for D straight samples; hist holds raw samples.
  initial begin
    logic [3:0] flip;
    logic [3:0] rise;
    bit         all;
    int         t;
    exp_t       e;
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else begin
        cyc++;
        hist.push_back(push_button);
        void'(hist.pop_front());
        flip = '0;
        for (int b = 0; b < 4; b++) begin
          all = 1'b1;
          for (int j = 0; j < D; j++)
            if (hist[j][b] == m_stable[b]) all = 1'b0;
          flip[b] = all;
        end
        rise = flip & ~m_stable;
        m_stable = m_stable ^ flip;
        if (rise != 4'h0) begin
          if (rise[3]) m_count = 0;
          else if (rise[2]) begin
            t = int'(toggle_switch[3:0]);
            m_count = (t > CM) ? CM : t;
          end else if (rise[1]) m_count = (m_count == 0) ? CM : m_count - 1;
          else m_count = (m_count + 1) % (CM + 1);
          e.pulse = rise;
          e.idx = 2'd0;
          for (int b = 3; b >= 0; b--) if (rise[b]) e.idx = 2'(b);
          e.cnt = m_count;
          e.cyc = cyc + 1;
          sb.push_back(e);
        end
      end
    end
  end

  // Monitor: pops one record per observed strobe, checks count/LEDs next cycle.
  initial begin
    bit   pend;
    exp_t cur;
    pend = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("count", int'(count), cur.cnt);
          chk("green_led", int'(green_led), CM - cur.cnt);
          chk("red_led", int'(red_led), (1 << cur.cnt) - 1);
          pend = 1'b0;
        end
        if (press_valid || press_pulse != 4'h0) begin
          if (sb.size() == 0) begin
            chk("unexpected_pulse", int'(press_pulse), 0);
          end else begin
            cur = sb.pop_front();
            chk("press_pulse", int'(press_pulse), int'(cur.pulse));
            chk("press_valid", int'(press_valid), 1);
            chk("press_index", int'(press_index), int'(cur.idx));
            chk("pulse_cycle", cyc, cur.cyc);
            pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic reset_check(input string name);
    reset_n = 1'b0;
    #1;
    chk({name, "_pulse"}, int'(press_pulse), 0);
    chk({name, "_valid"}, int'(press_valid), 0);
    chk({name, "_index"}, int'(press_index), 0);
    chk({name, "_count"}, int'(count), 0);
    chk({name, "_green"}, int'(green_led), CM);
    chk({name, "_red"}, int'(red_led), 0);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic settle(input string name);
    repeat (D + 6) @(negedge clock);
    chk({name, "_sb_empty"}, sb.size(), 0);
    chk({name, "_count"}, int'(count), m_count);
  endtask

  task automatic tap(input logic [3:0] mask);
    push_button = mask;
    repeat (D + 3) @(negedge clock);
    push_button = 4'h0;
    repeat (D + 3) @(negedge clock);
  endtask

  task automatic wait_pulse(input string name);
    int n;
    n = 0;
    while (!press_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk(name, int'(press_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    reset_check("por");
    release_reset();

    push_button = 4'h1;
    repeat (20) @(negedge clock);
    push_button = 4'h0;
    settle("hold20");
    chk("hold20_exact", int'(count), 1);

    for (int i = 0; i < 7; i++) tap(4'h1);
    settle("wrap");
    chk("wrap_exact", int'(count), 0);

    tap(4'h2);
    settle("dec_wrap");
    chk("dec_wrap_green", int'(green_led), 0);
    tap(4'h2);
    settle("dec");

    for (int i = 0; i < 5; i++) begin
      push_button = 4'h1;
      repeat (3) @(negedge clock);
      push_button = 4'h0;
      repeat (3) @(negedge clock);
    end
    settle("glitch");
    push_button = 4'h1;
    repeat (6) @(negedge clock);
    push_button = 4'h0;
    settle("clean6");

    toggle_switch = 8'h0C;
    tap(4'h4);
    settle("load_sat");
    chk("load_sat_exact", int'(count), 7);
    toggle_switch = 8'h03;
    tap(4'h4);
    settle("load3");
    tap(4'h9);
    settle("clr_inc");
    chk("clr_inc_exact", int'(count), 0);

    toggle_switch = 8'h05;
    tap(4'h4);
    settle("load5");
    push_button = 4'h1;
    repeat (3) @(negedge clock);
    #2;
    reset_check("rst_debounce");
    release_reset();
    settle("post_rst1");
    chk("post_rst1_exact", int'(count), 1);
    push_button = 4'h0;
    repeat (D + 4) @(negedge clock);
    push_button = 4'h1;
    wait_pulse("pulse_before_rst");
    #2;
    reset_check("rst_pulse");
    release_reset();
    settle("post_rst2");
    chk("post_rst2_exact", int'(count), 1);
    push_button = 4'h0;
    settle("post_rst2_rel");

    for (int r = 0; r < 6; r++) begin
      toggle_switch = 8'($urandom);
      for (int i = 0; i < 40; i++) begin
        push_button = 4'($urandom);
        repeat ($urandom_range(1, 7)) @(negedge clock);
      end
      push_button = 4'h0;
      repeat (D + 4) @(negedge clock);
      settle("rand");
    end

    chk("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
